// File: rtl/mips_data_mem_resp.sv
// Data-memory responder for the MIPS load/store port: byte array, big-endian words.
// Latency: request accepted at edge N -> resp_valid after edge N+1+WAIT_CYCLES.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
// Optional macro MIPS_DMEM_ALIGN_CHECK_EN: misaligned addresses respond with an error.
module mips_data_mem_resp #(
  parameter int    MEM_BYTES   = 1024,
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [7:0]  mem [MEM_BYTES];

  logic              access;
  logic              addr_err;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       rd_word;

  // Ready is a pure state decode so the requester sees no path from req_valid.
  assign req_ready = (state == S_IDLE);

  // The access edge is the last WAIT cycle, once the countdown has expired.
  assign access = (state == S_WAIT) && (cnt == 4'd0);

`ifdef MIPS_DMEM_ALIGN_CHECK_EN
  // Misaligned words are rejected just like out-of-range addresses.
  assign addr_err = (|cap_addr[31:ADDR_W]) | (|cap_addr[1:0]);
`else
  // Low address bits select a byte within the word and are ignored here.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^cap_addr[1:0];
  assign addr_err = |cap_addr[31:ADDR_W];
`endif

  // Byte indices of the enclosing aligned word, most significant byte first.
  assign a0 = {cap_addr[ADDR_W-1:2], 2'b00};
  assign a1 = {cap_addr[ADDR_W-1:2], 2'b01};
  assign a2 = {cap_addr[ADDR_W-1:2], 2'b10};
  assign a3 = {cap_addr[ADDR_W-1:2], 2'b11};
  assign rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};

  // Commit all four store bytes together on the access edge; the array has no reset.
  always_ff @(posedge clock) begin
    if (access && cap_write && !addr_err) begin
      mem[a0] <= cap_wdata[31:24];
      mem[a1] <= cap_wdata[23:16];
      mem[a2] <= cap_wdata[15:8];
      mem[a3] <= cap_wdata[7:0];
    end
  end

  // Request/wait/response sequencer with registered response outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      cap_write  <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cnt       <= 4'(WAIT_CYCLES);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= addr_err;
            resp_rdata <= (!cap_write && !addr_err) ? rd_word : 32'd0;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_data_mem_resp.sv
// Directed bench for mips_data_mem_resp: a WAIT_CYCLES=2 instance for the main
// sequence and a WAIT_CYCLES=0 instance for the minimum-latency case.
module tb_mips_data_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_resp_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  mips_data_mem_resp #(.MEM_BYTES(1024), .ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clock(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mips_data_mem_resp #(.MEM_BYTES(1024), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clock(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a request, wait for acceptance, return edges from accept to resp_valid.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    chk("accept_timeout", {31'd0, (k < 50)}, 32'd1);
    @(negedge clk);
    // Garbage on the request inputs while busy must not disturb the captured request.
    req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    k = 0;
    while (!resp_valid && k < 50) begin @(negedge clk); k++; end
    chk("resp_timeout", {31'd0, (k < 50)}, 32'd1);
    lat = k;
  endtask

  task automatic collect(output logic [31:0] rd, output logic e);
    rd = resp_rdata; e = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("valid_clear", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;

    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_resp_ready = 0;
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
    chk("rst_rdata",      resp_rdata,          32'd0);
    chk("rst_err",        {31'd0, resp_err},   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Store then load back, with byte-order check in the array.
    issue(1'b1, 32'h10, 32'h1234_5678, lat);
    chk("lat_w2", lat, 32'd3);
    collect(rd, e);
    chk("st_rdata", rd, 32'd0);
    chk("st_err", {31'd0, e}, 32'd0);
    chk("mem10", {24'd0, dut.mem[16]}, 32'h12);
    chk("mem13", {24'd0, dut.mem[19]}, 32'h78);
    issue(1'b0, 32'h10, 32'h0, lat);
    collect(rd, e);
    chk("ld10_rdata", rd, 32'h1234_5678);
    chk("ld10_err", {31'd0, e}, 32'd0);

    // Out-of-range store must not alias onto word 0.
    issue(1'b1, 32'h0, 32'hA5A5_0001, lat);
    collect(rd, e);
    issue(1'b1, 32'h400, 32'hFFFF_FFFF, lat);
    chk("lat_err", lat, 32'd3);
    collect(rd, e);
    chk("st400_err", {31'd0, e}, 32'd1);
    chk("st400_rdata", rd, 32'd0);
    issue(1'b0, 32'h400, 32'h0, lat);
    collect(rd, e);
    chk("ld400_err", {31'd0, e}, 32'd1);
    chk("ld400_rdata", rd, 32'd0);
    issue(1'b0, 32'h0, 32'h0, lat);
    collect(rd, e);
    chk("ld0_rdata", rd, 32'hA5A5_0001);

    // Response held while resp_ready stays low.
    issue(1'b0, 32'h10, 32'h0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, 32'h1234_5678);
      chk("hold_err", {31'd0, resp_err}, 32'd0);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_hs_rdata", resp_rdata, 32'd0);

    // Reset during WAIT drops the store.
    issue(1'b1, 32'h20, 32'hCAFE_F00D, lat);
    collect(rd, e);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_in_wait", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_rdata", resp_rdata, 32'd0);
    chk("rst_mid_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 32'h20, 32'h0, lat);
    collect(rd, e);
    chk("ld20_after_rst", rd, 32'hCAFE_F00D);

    // Misaligned load.
    issue(1'b0, 32'h22, 32'h0, lat);
    collect(rd, e);
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    chk("ld22_err", {31'd0, e}, 32'd1);
    chk("ld22_rdata", rd, 32'd0);
`else
    chk("ld22_err", {31'd0, e}, 32'd0);
    chk("ld22_rdata", rd, 32'hCAFE_F00D);
`endif

    // Zero-wait instance: response one edge after acceptance.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      z_req_valid = 1'b1; z_req_write = (t == 0); z_req_addr = 32'h8; z_req_wdata = 32'h0BAD_F00D;
      chk("z_req_ready", {31'd0, z_req_ready}, 32'd1);
      @(negedge clk);
      z_req_valid = 1'b0;
      chk("z_valid_n0", {31'd0, z_resp_valid}, 32'd0);
      @(negedge clk);
      chk("z_valid_n1", {31'd0, z_resp_valid}, 32'd1);
      chk("z_rdata", z_resp_rdata, (t == 0) ? 32'd0 : 32'h0BAD_F00D);
      z_resp_ready = 1'b1;
      @(negedge clk);
      z_resp_ready = 1'b0;
      chk("z_req_ready_after", {31'd0, z_req_ready}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
